// File: rtl/traffic_light_controller_actuated.sv
// traffic_light_controller_actuated: actuated two-way intersection controller (clk/rst; ns_car, ew_car, ped_req, flash_mode in; six lamps, ped_walk and state_o out)
module traffic_light_controller_actuated #(
  parameter int CLOCK_FREQ_HZ = 50_000_000,
  parameter int GREEN_MIN_S   = 5,
  parameter int GREEN_MAX_S   = 20,
  parameter int YELLOW_TIME_S = 3,
  parameter int ALLRED_TIME_S = 1,
  parameter int PED_TIME_S    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       ped_walk,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_2  = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_t;
  localparam int T_GMIN = GREEN_MIN_S * CLOCK_FREQ_HZ;
  localparam int T_GMAX = GREEN_MAX_S * CLOCK_FREQ_HZ;
  localparam int T_Y    = YELLOW_TIME_S * CLOCK_FREQ_HZ;
  localparam int T_AR   = ALLRED_TIME_S * CLOCK_FREQ_HZ;
  localparam int T_PED  = PED_TIME_S * CLOCK_FREQ_HZ;
  localparam int T_HALF = (CLOCK_FREQ_HZ / 2 > 0) ? CLOCK_FREQ_HZ / 2 : 1;
  localparam int T_M1   = (T_GMAX > T_Y) ? T_GMAX : T_Y;
  localparam int T_M2   = (T_AR > T_PED) ? T_AR : T_PED;
  localparam int T_ALL  = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CW     = (T_ALL > 1) ? $clog2(T_ALL) : 1;
  localparam logic [CW-1:0] C_GMIN = CW'(T_GMIN - 1);
  localparam logic [CW-1:0] C_GMAX = CW'(T_GMAX - 1);
  localparam logic [CW-1:0] C_Y    = CW'(T_Y - 1);
  localparam logic [CW-1:0] C_AR   = CW'(T_AR - 1);
  localparam logic [CW-1:0] C_PED  = CW'(T_PED - 1);
  localparam logic [CW-1:0] C_HALF = CW'(T_HALF - 1);
  state_t          state_q, state_d, ar_next;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            next_dir_q, next_dir_d;
  logic            ped_q, ped_d;
  logic            flag_q, flag_d;
  logic            entering, flash_wrap;
  logic [6:0]      lamp_q;
  function automatic logic [6:0] lamps(input state_t s, input logic f);
    case (s)
      NS_GREEN:  lamps = 7'b001_100_0;
      NS_YELLOW: lamps = 7'b010_100_0;
      EW_GREEN:  lamps = 7'b100_001_0;
      EW_YELLOW: lamps = 7'b100_010_0;
      PED_WALK:  lamps = 7'b100_100_1;
      FLASH:     lamps = {1'b0, f, 1'b0, f, 3'b000};
      default:   lamps = 7'b100_100_0;
    endcase
  endfunction
  always_comb begin
    state_d    = state_q;
    next_dir_d = next_dir_q;
    ar_next    = flash_mode ? FLASH : ped_q ? PED_WALK : (state_q == ALLRED_1) ? EW_GREEN : NS_GREEN;
    case (state_q)
      NS_GREEN:  if ((cnt_q >= C_GMIN && (ew_car | ped_q)) || cnt_q == C_GMAX) state_d = NS_YELLOW;
      EW_GREEN:  if ((cnt_q >= C_GMIN && (ns_car | ped_q)) || cnt_q == C_GMAX) state_d = EW_YELLOW;
      NS_YELLOW: if (cnt_q == C_Y) state_d = ALLRED_1;
      EW_YELLOW: if (cnt_q == C_Y) state_d = ALLRED_2;
      ALLRED_1, ALLRED_2: if (cnt_q == C_AR) begin
        state_d    = ar_next;
        next_dir_d = (state_q == ALLRED_1);
      end
      PED_WALK:  if (cnt_q == C_PED) state_d = next_dir_q ? EW_GREEN : NS_GREEN;
      FLASH:     if (!flash_mode) state_d = ALLRED_2;
      default:   state_d = ALLRED_2;
    endcase
    entering   = (state_d != state_q);
    flash_wrap = (state_q == FLASH) && (cnt_q == C_HALF);
    cnt_d      = (entering || flash_wrap) ? '0 : cnt_q + 1'b1;
    flag_d     = (state_d != FLASH) ? 1'b0 : entering ? 1'b1 : flash_wrap ? ~flag_q : flag_q;
    ped_d      = ped_req | (ped_q & ~(entering && state_d == PED_WALK));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ALLRED_2;
      cnt_q      <= '0;
      next_dir_q <= 1'b0;
      ped_q      <= 1'b0;
      flag_q     <= 1'b0;
      lamp_q     <= lamps(ALLRED_2, 1'b0);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      next_dir_q <= next_dir_d;
      ped_q      <= ped_d;
      flag_q     <= flag_d;
      lamp_q     <= lamps(state_d, flag_d);
    end
  end
  assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk} = lamp_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_traffic_light_controller_actuated.sv
// tb_traffic_light_controller_actuated: directed self-checking bench for the actuated traffic light controller
module tb_traffic_light_controller_actuated;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ns_car = 1'b0, ew_car = 1'b0, ped_req = 1'b0, flash_mode = 1'b0;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk;
  logic [2:0] state_o;
  logic [6:0] lamps;
  int checks = 0;
  int errors = 0;
  assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk};
  traffic_light_controller_actuated #(
    .CLOCK_FREQ_HZ(10), .GREEN_MIN_S(1), .GREEN_MAX_S(3),
    .YELLOW_TIME_S(1), .ALLRED_TIME_S(1), .PED_TIME_S(2)
  ) dut (
    .clk(clk), .rst(rst), .ns_car(ns_car), .ew_car(ew_car), .ped_req(ped_req),
    .flash_mode(flash_mode), .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green), .ped_walk(ped_walk),
    .state_o(state_o)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] exp_lamps(input int s);
    case (s)
      0:       exp_lamps = 7'b001_100_0;
      1:       exp_lamps = 7'b010_100_0;
      3:       exp_lamps = 7'b100_001_0;
      4:       exp_lamps = 7'b100_010_0;
      6:       exp_lamps = 7'b100_100_1;
      default: exp_lamps = 7'b100_100_0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    chk("no_conflict", {31'd0, (ns_green & ew_green) | ((ns_green | ew_green) & ped_walk)}, 32'd0);
  endtask
  task automatic phase(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("state s=%0d cyc=%0d", s, i), {29'd0, state_o}, s);
      chk($sformatf("lamps s=%0d cyc=%0d", s, i), {25'd0, lamps}, {25'd0, exp_lamps(s)});
      tick();
    end
  endtask
  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("reset_state", {29'd0, state_o}, 32'd5);
    chk("reset_lamps", {25'd0, lamps}, {25'd0, 7'b100_100_0});
    rst = 1'b0;
    phase(5, 10); phase(0, 30); phase(1, 10); phase(2, 10);
    phase(3, 30); phase(4, 10); phase(5, 10);
    ew_car = 1'b1;
    phase(0, 10);
    ew_car = 1'b0;
    phase(1, 10); phase(2, 10);
    ns_car = 1'b1;
    tick();
    ns_car = 1'b0;
    phase(3, 29); phase(4, 10); phase(5, 10);
    ped_req = 1'b1;
    phase(0, 1);
    ped_req = 1'b0;
    phase(0, 9); phase(1, 10); phase(2, 10); phase(6, 20);
    ped_req = 1'b1;
    phase(3, 1);
    ped_req = 1'b0;
    phase(3, 9); phase(4, 10); phase(5, 9);
    ped_req = 1'b1;
    phase(5, 1);
    ped_req = 1'b0;
    phase(6, 20); phase(0, 10); phase(1, 10); phase(2, 10); phase(6, 20);
    phase(3, 5);
    flash_mode = 1'b1;
    phase(3, 25); phase(4, 10); phase(5, 10);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("flash_state cyc=%0d", i), {29'd0, state_o}, 32'd7);
      chk($sformatf("flash_lamps cyc=%0d", i), {25'd0, lamps}, ((i / 5) % 2 == 0) ? 32'h28 : 32'h0);
      tick();
    end
    flash_mode = 1'b0;
    chk("flash_last_state", {29'd0, state_o}, 32'd7);
    chk("flash_last_lamps", {25'd0, lamps}, 32'h0);
    tick();
    phase(5, 10); phase(0, 30); phase(1, 10); phase(2, 10);
    phase(3, 3);
    ped_req = 1'b1;
    phase(3, 1);
    ped_req = 1'b0;
    phase(3, 2);
    rst = 1'b1;
    tick();
    chk("midreset_state", {29'd0, state_o}, 32'd5);
    chk("midreset_lamps", {25'd0, lamps}, {25'd0, 7'b100_100_0});
    rst = 1'b0;
    phase(5, 10); phase(0, 30); phase(1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
